// File: rtl/i2s_rx_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : i2s_rx_pkg
// Description : Shared defaults and FSM state encoding for the I2S receive
//               frame controller and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_rx_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_CNT_WIDTH  = 8;

  // Frame-pairing FSM states
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_LEFT  = 2'd1,
    ST_WAIT_RIGHT = 2'd2
  } state_e;

endpackage : i2s_rx_pkg
`default_nettype wire

// File: rtl/i2s_rx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : i2s_rx_frame_if
// Description : Stereo frame output handshake (valid/ready) between the
//               frame controller (master) and the host (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_rx_frame_if
  import i2s_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] o_frame_left;
  logic [DATA_WIDTH-1:0] o_frame_right;
  logic                  o_frame_vld;
  logic                  i_frame_rdy;

  modport master (
    output o_frame_left,
    output o_frame_right,
    output o_frame_vld,
    input  i_frame_rdy
  );

  modport slave (
    input  o_frame_left,
    input  o_frame_right,
    input  o_frame_vld,
    output i_frame_rdy
  );

endinterface : i2s_rx_frame_if
`default_nettype wire

// File: rtl/i2s_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : i2s_frame_fifo
// Description : Synchronous FIFO of stereo frames. The head entry is presented
//               combinationally from the storage array; a push into a full
//               FIFO is accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_frame_fifo
  import i2s_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * DEF_DATA_WIDTH,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_push_data,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_head_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic      [AW:0]      o_fill
);

  localparam logic [AW:0] C_FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      fill_q;

  logic w_empty;
  logic w_full;
  logic w_rd_en;
  logic w_wr_en;

  assign w_empty = (fill_q == '0);
  assign w_full  = (fill_q == C_FULL_LVL);
  // When full, a simultaneous pop frees the slot being written this edge
  assign w_rd_en = i_pop & ~w_empty;
  assign w_wr_en = i_push & (~w_full | w_rd_en);

  // Storage array; cleared on reset so the head reads zero after reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_wr_en) begin
      mem_q[wr_ptr_q] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (w_wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  assign o_head_data = mem_q[rd_ptr_q];
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_fill      = fill_q;

endmodule : i2s_frame_fifo
`default_nettype wire

// File: rtl/i2s_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2s_rx_frame_ctrl
// Description : Pairs left/right I2S sample pulses into stereo frames, buffers
//               them in a FIFO and tracks drop / pairing-error statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_frame_ctrl
  import i2s_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
  localparam int unsigned FW        = $clog2(FIFO_DEPTH) + 1
) (
  input  wire logic                  i_sck,
  input  wire logic                  i_sys_rst,
  input  wire logic                  i_enable,
  input  wire logic [DATA_WIDTH-1:0] i_left_data,
  input  wire logic                  i_left_vld,
  input  wire logic [DATA_WIDTH-1:0] i_right_data,
  input  wire logic                  i_right_vld,
  i2s_rx_frame_if.master             frame_if,
  output logic      [FW-1:0]         o_fill,
  output logic                       o_overflow,
  output logic      [CNT_WIDTH-1:0]  o_drop_cnt,
  output logic      [CNT_WIDTH-1:0]  o_sync_err_cnt,
  input  wire logic                  i_clr_stat
);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   left_q;
  logic                    overflow_q;
  logic [CNT_WIDTH-1:0]    drop_cnt_q;
  logic [CNT_WIDTH-1:0]    sync_err_q;

  logic                    w_push;
  logic                    w_sync_err;
  logic                    w_drop;
  logic                    w_full;
  logic                    w_empty;
  logic [2*DATA_WIDTH-1:0] w_head;

  // Push and pairing-error strobes decoded from the current state and pulses
  always_comb begin
    w_push     = 1'b0;
    w_sync_err = 1'b0;
    if (i_enable) begin
      case (state_q)
        ST_WAIT_LEFT: begin
          w_sync_err = i_left_vld & i_right_vld;
        end
        ST_WAIT_RIGHT: begin
          // A left pulse here is always an error, alone or with a right one
          w_sync_err = i_left_vld;
          w_push     = i_right_vld & ~i_left_vld;
        end
        default: ;
      endcase
    end
  end

  // A push is lost only when full and the host is not popping this cycle
  assign w_drop = w_push & w_full & ~(frame_if.i_frame_rdy & ~w_empty);

  // Pairing FSM with the held left sample
  always_ff @(posedge i_sck or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q <= ST_IDLE;
      left_q  <= '0;
    end else if (!i_enable) begin
      state_q <= ST_IDLE;
      left_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_WAIT_LEFT;
        end
        ST_WAIT_LEFT: begin
          if (i_left_vld && !i_right_vld) begin
            left_q  <= i_left_data;
            state_q <= ST_WAIT_RIGHT;
          end
        end
        ST_WAIT_RIGHT: begin
          if (i_left_vld && i_right_vld) begin
            left_q  <= '0;
            state_q <= ST_WAIT_LEFT;
          end else if (i_left_vld) begin
            left_q  <= i_left_data;
          end else if (i_right_vld) begin
            state_q <= ST_WAIT_LEFT;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          left_q  <= '0;
        end
      endcase
    end
  end

  // Sticky overflow and saturating counters; a clear overrides any event
  always_ff @(posedge i_sck or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      sync_err_q <= '0;
    end else if (i_clr_stat) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      sync_err_q <= '0;
    end else begin
      if (w_drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
      if (w_sync_err && (sync_err_q != '1)) begin
        sync_err_q <= sync_err_q + 1'b1;
      end
    end
  end

  i2s_frame_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_sck),
    .i_rst       (i_sys_rst),
    .i_push      (w_push),
    .i_push_data ({left_q, i_right_data}),
    .i_pop       (frame_if.i_frame_rdy),
    .o_head_data (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_fill      (o_fill)
  );

  assign frame_if.o_frame_vld   = ~w_empty;
  assign frame_if.o_frame_left  = w_head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign frame_if.o_frame_right = w_head[DATA_WIDTH-1:0];
  assign o_overflow             = overflow_q;
  assign o_drop_cnt             = drop_cnt_q;
  assign o_sync_err_cnt         = sync_err_q;

endmodule : i2s_rx_frame_ctrl
`default_nettype wire

// File: tb/tb_i2s_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_rx_frame_ctrl
// Description : Self-checking bench for i2s_rx_frame_ctrl using a frame
//               scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_rx_frame_ctrl;
  import i2s_rx_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [DW-1:0] left_data;
  logic          left_vld;
  logic [DW-1:0] right_data;
  logic          right_vld;
  logic          clr_stat;
  logic [2:0]    fill;
  logic          overflow;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  logic [2*DW-1:0] sb[$];

  i2s_rx_frame_if #(.DATA_WIDTH(DW)) frm ();

  i2s_rx_frame_ctrl #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_sck          (clk),
    .i_sys_rst      (rst),
    .i_enable       (enable),
    .i_left_data    (left_data),
    .i_left_vld     (left_vld),
    .i_right_data   (right_data),
    .i_right_vld    (right_vld),
    .frame_if       (frm),
    .o_fill         (fill),
    .o_overflow     (overflow),
    .o_drop_cnt     (drop_cnt),
    .o_sync_err_cnt (err_cnt),
    .i_clr_stat     (clr_stat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_left(input logic [DW-1:0] d);
    left_data = d; left_vld = 1'b1; tick(); left_vld = 1'b0; left_data = '0;
  endtask

  task automatic send_right(input logic [DW-1:0] d);
    right_data = d; right_vld = 1'b1; tick(); right_vld = 1'b0; right_data = '0;
  endtask

  task automatic send_both(input logic [DW-1:0] l, input logic [DW-1:0] r);
    left_data = l; right_data = r; left_vld = 1'b1; right_vld = 1'b1;
    tick();
    left_vld = 1'b0; right_vld = 1'b0; left_data = '0; right_data = '0;
  endtask

  // Pops n frames with ready high, comparing each head against the scoreboard
  task automatic drain(input int n);
    logic [2*DW-1:0] exp;
    frm.i_frame_rdy = 1'b1;
    for (int k = 0; k < n; k++) begin
      int waitc = 0;
      while (frm.o_frame_vld !== 1'b1 && waitc < 8) begin tick(); waitc++; end
      checks++;
      if (frm.o_frame_vld !== 1'b1 || sb.size() == 0) begin
        failures++;
        $display("FAIL drain_vld: frame %0d vld=%b sb_size=%0d required vld=1", k, frm.o_frame_vld, sb.size());
        break;
      end
      exp = sb.pop_front();
      checks++;
      if ({frm.o_frame_left, frm.o_frame_right} !== exp) begin
        failures++;
        $display("FAIL drain_data: frame %0d got %h_%h required %h", k, frm.o_frame_left, frm.o_frame_right, exp);
      end
      tick();
    end
    frm.i_frame_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; left_vld = 1'b0; right_vld = 1'b0;
    left_data = '0; right_data = '0; clr_stat = 1'b0; frm.i_frame_rdy = 1'b0;
    tick(); tick();
    checks++; if (frm.o_frame_vld !== 1'b0) begin failures++; $display("FAIL rst_vld: got %b required 0", frm.o_frame_vld); end
    checks++; if (fill !== 3'd0) begin failures++; $display("FAIL rst_fill: got %0d required 0", fill); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== '0 || err_cnt !== '0) begin failures++; $display("FAIL rst_stat: ovf=%b drop=%0d err=%0d required 0/0/0", overflow, drop_cnt, err_cnt); end
    checks++; if (frm.o_frame_left !== '0 || frm.o_frame_right !== '0) begin failures++; $display("FAIL rst_data: got %h_%h required 0", frm.o_frame_left, frm.o_frame_right); end
    checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL rst_state: got %0d required IDLE", dut.state_q); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    enable = 1'b1; tick();
    send_left(16'h1234);
    send_right(16'hABCD);
    sb.push_back({16'h1234, 16'hABCD});
    checks++; if (frm.o_frame_vld !== 1'b1 || fill !== 3'd1) begin failures++; $display("FAIL basic_vld: vld=%b fill=%0d required 1/1", frm.o_frame_vld, fill); end
    checks++; if (frm.o_frame_left !== 16'h1234 || frm.o_frame_right !== 16'hABCD) begin failures++; $display("FAIL basic_data: got %h_%h required 1234_abcd", frm.o_frame_left, frm.o_frame_right); end
    tick(); tick();
    checks++; if (frm.o_frame_left !== 16'h1234 || frm.o_frame_right !== 16'hABCD || fill !== 3'd1) begin failures++; $display("FAIL basic_hold: got %h_%h fill=%0d required 1234_abcd fill=1", frm.o_frame_left, frm.o_frame_right, fill); end
    drain(1);
    checks++; if (frm.o_frame_vld !== 1'b0 || fill !== 3'd0) begin failures++; $display("FAIL basic_empty: vld=%b fill=%0d required 0/0", frm.o_frame_vld, fill); end
  endtask

  task automatic test_right_first();
    enable = 1'b0; tick();
    enable = 1'b1; right_data = 16'h5555; right_vld = 1'b1; tick();
    right_data = 16'h6666; tick();
    right_vld = 1'b0; right_data = '0;
    checks++; if (fill !== 3'd0) begin failures++; $display("FAIL rfirst_fill: got %0d required 0", fill); end
    send_left(16'h1111);
    send_right(16'h2222);
    sb.push_back({16'h1111, 16'h2222});
    checks++; if (err_cnt !== 8'd0 || fill !== 3'd1) begin failures++; $display("FAIL rfirst_err: err=%0d fill=%0d required 0/1", err_cnt, fill); end
    drain(1);
  endtask

  task automatic test_left_resync();
    send_left(16'h0001);
    send_left(16'h0002);
    send_right(16'h0003);
    sb.push_back({16'h0002, 16'h0003});
    checks++; if (err_cnt !== 8'd1 || fill !== 3'd1) begin failures++; $display("FAIL resync: err=%0d fill=%0d required 1/1", err_cnt, fill); end
    drain(1);
  endtask

  task automatic test_both_pulses();
    send_both(16'hAAAA, 16'hBBBB);
    send_left(16'h0007);
    send_both(16'h0008, 16'h0009);
    send_right(16'h9999);
    checks++; if (fill !== 3'd0) begin failures++; $display("FAIL both_nopush: fill=%0d required 0", fill); end
    send_left(16'h000C);
    send_right(16'h000D);
    sb.push_back({16'h000C, 16'h000D});
    checks++; if (err_cnt !== 8'd3 || fill !== 3'd1) begin failures++; $display("FAIL both_err: err=%0d fill=%0d required 3/1", err_cnt, fill); end
    drain(1);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      send_left(16'h0100 + 16'(i));
      send_right(16'h0200 + 16'(i));
      if (i <= DEPTH) sb.push_back({16'h0100 + 16'(i), 16'h0200 + 16'(i)});
    end
    checks++; if (fill !== 3'd4 || drop_cnt !== 8'd1 || overflow !== 1'b1) begin failures++; $display("FAIL ovf: fill=%0d drop=%0d ovf=%b required 4/1/1", fill, drop_cnt, overflow); end
  endtask

  task automatic test_full_pop_push();
    logic [2*DW-1:0] exp;
    send_left(16'h0306);
    right_data = 16'h0406; right_vld = 1'b1; frm.i_frame_rdy = 1'b1;
    exp = sb.pop_front();
    checks++; if ({frm.o_frame_left, frm.o_frame_right} !== exp) begin failures++; $display("FAIL fpp_head: got %h_%h required %h", frm.o_frame_left, frm.o_frame_right, exp); end
    sb.push_back({16'h0306, 16'h0406});
    tick();
    right_vld = 1'b0; right_data = '0; frm.i_frame_rdy = 1'b0;
    checks++; if (fill !== 3'd4 || drop_cnt !== 8'd1) begin failures++; $display("FAIL fpp_fill: fill=%0d drop=%0d required 4/1", fill, drop_cnt); end
    drain(4);
    checks++; if (fill !== 3'd0) begin failures++; $display("FAIL fpp_drained: fill=%0d required 0", fill); end
  endtask

  task automatic test_clr_collision();
    left_vld = 1'b1; right_vld = 1'b1; clr_stat = 1'b1;
    tick();
    left_vld = 1'b0; right_vld = 1'b0; clr_stat = 1'b0;
    checks++; if (err_cnt !== 8'd0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin failures++; $display("FAIL clr: err=%0d drop=%0d ovf=%b required 0/0/0", err_cnt, drop_cnt, overflow); end
  endtask

  task automatic test_disable();
    send_left(16'h0A01);
    send_right(16'h0A02);
    sb.push_back({16'h0A01, 16'h0A02});
    send_left(16'h0A03);
    enable = 1'b0; tick();
    checks++; if (dut.state_q !== ST_IDLE || dut.left_q !== '0) begin failures++; $display("FAIL dis_state: state=%0d left=%h required IDLE/0", dut.state_q, dut.left_q); end
    checks++; if (fill !== 3'd1) begin failures++; $display("FAIL dis_fill: fill=%0d required 1", fill); end
    drain(1);
    enable = 1'b1; tick();
    send_right(16'h0A04);
    checks++; if (fill !== 3'd0 || err_cnt !== 8'd0) begin failures++; $display("FAIL dis_right: fill=%0d err=%0d required 0/0", fill, err_cnt); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) send_both(16'(i), 16'(i + 1));
    checks++; if (err_cnt !== 8'hFF) begin failures++; $display("FAIL sat: err=%0d required 255", err_cnt); end
    clr_stat = 1'b1; tick(); clr_stat = 1'b0;
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL sat_clr: err=%0d required 0", err_cnt); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      send_left(16'h0B00 + 16'(i));
      send_right(16'h0C00 + 16'(i));
      sb.push_back({16'h0B00 + 16'(i), 16'h0C00 + 16'(i)});
    end
    send_left(16'h0077);
    checks++; if (fill !== 3'd3 || dut.state_q !== ST_WAIT_RIGHT) begin failures++; $display("FAIL mid_pre: fill=%0d state=%0d required 3/WAIT_RIGHT", fill, dut.state_q); end
    #2 rst = 1'b1;
    #1;
    checks++; if (fill !== 3'd0 || frm.o_frame_vld !== 1'b0) begin failures++; $display("FAIL mid_rst: fill=%0d vld=%b required 0/0", fill, frm.o_frame_vld); end
    checks++; if (dut.state_q !== ST_IDLE || frm.o_frame_left !== '0 || frm.o_frame_right !== '0) begin failures++; $display("FAIL mid_state: state=%0d head=%h_%h required IDLE/0", dut.state_q, frm.o_frame_left, frm.o_frame_right); end
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_right_first();
    test_left_resync();
    test_both_pulses();
    test_overflow();
    test_full_pop_push();
    test_clr_collision();
    test_disable();
    test_saturation();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_i2s_rx_frame_ctrl
`default_nettype wire
